// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle shared between the arbiter (master) and the peripheral (slave).
// Handshake: in SETUP the master raises psel with penable low; in ACCESS it
// raises penable and holds paddr/pwrite/pwdata stable until the slave answers
// with pready=1, at which point prdata is sampled (reads) on that same edge.
interface apb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ requesters.
// Requester handshake: a requester holds req_valid (with write/addr/wdata)
// until it sees a one-cycle req_ready; the completion comes back later as a
// one-cycle rsp_valid bit with rsp_rdata/rsp_err on the shared response bus.
// Optional macro APB_TIMEOUT_EN: abort an ACCESS phase after TIMEOUT_CYCLES
// cycles without pready and report it with rsp_err=1, rdata=32'hDEAD_BEEF.
module apb_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [2:0]                grant_id,
  output logic                      busy,
  output logic [1:0]                state_dbg_o,
  apb_if.master                     apb
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Reject configurations the 3-bit grant index or the timeout counter cannot hold.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("apb_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  state_e              state_q, state_d;
  logic [2:0]          last_q, last_d;
  logic [2:0]          grant_id_q, grant_id_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                found;
  logic [2:0]          pick;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_err_q, rsp_err_d;
`endif

  // Round-robin pick: first valid requester scanning upward from last_grant+1.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && |(req_valid & (NUM_REQ'(1) << ((int'(last_q) + k) % NUM_REQ)))) begin
        found = 1'b1;
        pick  = 3'((int'(last_q) + k) % NUM_REQ);
      end
    end
  end

  // FSM next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_id_d  = grant_id_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
`ifdef APB_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = SETUP;
          psel_d      = 1'b1;
          req_ready_d = NUM_REQ'(1) << pick;
          grant_id_d  = pick;
          last_d      = pick;
          pwrite_d    = |(req_write & (NUM_REQ'(1) << pick));
          paddr_d     = ADDR_W'(req_addr >> (int'(pick) * ADDR_W));
          pwdata_d    = DATA_W'(req_wdata >> (int'(pick) * DATA_W));
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        // pready wins over the timeout when both land in the same cycle.
        if (apb.pready) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << grant_id_q;
          rsp_rdata_d = pwrite_q ? '0 : apb.prdata;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = NUM_REQ'(1) << grant_id_q;
          rsp_rdata_d = DATA_W'(32'hDEAD_BEEF);
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 3'(NUM_REQ - 1);
      grant_id_q  <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_id_q  <= grant_id_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

`ifdef APB_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign grant_id    = grant_id_q;
  // psel is high exactly in SETUP and ACCESS.
  assign busy        = psel_q;
  assign state_dbg_o = state_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios plus randomized requests,
// wait states and read data, checked against a transaction-level model of
// round-robin arbitration and APB timing.
module tb_apb_master_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err, busy;
  logic [2:0]      grant_id;
  logic [1:0]      state_dbg;

  apb_if #(.ADDR_W(AW), .DATA_W(DW)) apb_bus ();

  apb_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .grant_id(grant_id), .busy(busy), .state_dbg_o(state_dbg),
    .apb(apb_bus)
  );

  // Requester model state, packed onto the DUT buses
  logic          pv[N];
  logic          pw[N];
  logic [AW-1:0] pa[N];
  logic [DW-1:0] pd[N];
  int            last;
  int            n_vec = 0;
  int            n_err = 0;

  always_comb begin
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int r = 0; r < N; r++) begin
      req_valid[r]            = pv[r];
      req_write[r]            = pw[r];
      req_addr[r*AW +: AW]    = pa[r];
      req_wdata[r*DW +: DW]   = pd[r];
    end
  end

  // Scoreboard check
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int r);
    pv[r] = 1'b1;
    pw[r] = 1'($urandom_range(0, 1));
    pa[r] = {$urandom, 2'b00} >> 0;
    pd[r] = $urandom;
  endtask

  // Reference arbitration: first pending requester after the last winner.
  function automatic int model_pick();
    for (int k = 1; k <= N; k++)
      if (pv[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // One complete transfer starting from an IDLE cycle with a request pending.
  task automatic serve(input int ws, input logic [DW-1:0] rd, input bit rearm);
    int            g;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    g = model_pick();
    if (g < 0) begin
      chk("serve_no_request", 64'(g), 64'(0));
      return;
    end
    last = g;
    w = pw[g]; a = pa[g]; d = pd[g];
    tick();
    chk("setup_psel", 64'(apb_bus.psel), 64'(1));
    chk("setup_penable", 64'(apb_bus.penable), 64'(0));
    chk("setup_ready", 64'(req_ready), 64'(1) << g);
    chk("setup_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("setup_grant_id", 64'(grant_id), 64'(g));
    chk("setup_paddr", 64'(apb_bus.paddr), 64'(a));
    chk("setup_pwrite", 64'(apb_bus.pwrite), 64'(w));
    chk("setup_pwdata", 64'(apb_bus.pwdata), 64'(d));
    chk("setup_busy", 64'(busy), 64'(1));
    pv[g] = 1'b0;
    if (rearm) new_req(g);
    apb_bus.pready = 1'($urandom_range(0, 1));
    for (int i = 0; i <= ws; i++) begin
      tick();
      chk("access_psel", 64'(apb_bus.psel), 64'(1));
      chk("access_penable", 64'(apb_bus.penable), 64'(1));
      chk("access_paddr", 64'(apb_bus.paddr), 64'(a));
      chk("access_pwrite", 64'(apb_bus.pwrite), 64'(w));
      chk("access_pwdata", 64'(apb_bus.pwdata), 64'(d));
      chk("access_ready", 64'(req_ready), 64'(0));
      chk("access_rsp_valid", 64'(rsp_valid), 64'(0));
      apb_bus.pready = (i == ws);
      apb_bus.prdata = (i == ws) ? rd : $urandom;
    end
    tick();
    chk("rsp_valid", 64'(rsp_valid), 64'(1) << g);
    chk("rsp_rdata", 64'(rsp_rdata), w ? 64'(0) : 64'(rd));
    chk("rsp_err", 64'(rsp_err), 64'(0));
    chk("rsp_psel", 64'(apb_bus.psel), 64'(0));
    chk("rsp_penable", 64'(apb_bus.penable), 64'(0));
    chk("rsp_busy", 64'(busy), 64'(0));
    chk("rsp_grant_id", 64'(grant_id), 64'(g));
    apb_bus.pready = 1'($urandom_range(0, 1));
    apb_bus.prdata = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int r = 0; r < N; r++) pv[r] = 1'b0;
    apb_bus.pready = 1'b0;
    tick();
    tick();
    rst  = 1'b0;
    last = N - 1;
  endtask

  // Bound on total run time
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Directed and randomized stimulus
  initial begin
    logic [DW-1:0] rd;
    for (int r = 0; r < N; r++) begin
      pv[r] = 1'b0; pw[r] = 1'b0; pa[r] = '0; pd[r] = '0;
    end
    apb_bus.prdata = '0;
    rst  = 1'b1;
    last = N - 1;
    do_reset();
    rst = 1'b1;
    #1;
    chk("reset_psel", 64'(apb_bus.psel), 64'(0));
    chk("reset_penable", 64'(apb_bus.penable), 64'(0));
    chk("reset_pwrite", 64'(apb_bus.pwrite), 64'(0));
    chk("reset_paddr", 64'(apb_bus.paddr), 64'(0));
    chk("reset_pwdata", 64'(apb_bus.pwdata), 64'(0));
    chk("reset_ready", 64'(req_ready), 64'(0));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("reset_rsp_err", 64'(rsp_err), 64'(0));
    chk("reset_grant_id", 64'(grant_id), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    do_reset();

    // Write with zero wait states from requester 0
    pv[0] = 1'b1; pw[0] = 1'b1; pa[0] = 32'h1000_0004; pd[0] = 32'hA5A5_0001;
    serve(0, $urandom, 1'b0);

    // Read with three wait states from requester 1
    pv[1] = 1'b1; pw[1] = 1'b0; pa[1] = 32'h0000_0020; pd[1] = $urandom;
    serve(3, 32'h1234_5678, 1'b0);

    // Nothing pending: bus stays idle
    tick();
    chk("idle_psel", 64'(apb_bus.psel), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));

    // Contention from reset: grants alternate 0,1,0,1
    do_reset();
    new_req(0);
    new_req(1);
    for (int t = 0; t < 4; t++) begin
      chk("contention_order", 64'(model_pick()), 64'(t % 2));
      serve($urandom_range(0, 2), $urandom, 1'b1);
    end
    for (int r = 0; r < N; r++) pv[r] = 1'b0;

    // Reset in the middle of ACCESS
    tick();
    new_req(0);
    tick();
    pv[0] = 1'b0;
    apb_bus.pready = 1'b0;
    tick();
    chk("pre_reset_penable", 64'(apb_bus.penable), 64'(1));
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_psel", 64'(apb_bus.psel), 64'(0));
    chk("async_rst_penable", 64'(apb_bus.penable), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    @(posedge clk);
    #1;
    rst  = 1'b0;
    last = N - 1;
    tick();
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("post_rst_psel", 64'(apb_bus.psel), 64'(0));
    new_req(1);
    chk("post_rst_single", 64'(model_pick()), 64'(1));
    serve(1, $urandom, 1'b0);
    do_reset();
    new_req(0);
    new_req(1);
    chk("post_rst_both", 64'(model_pick()), 64'(0));
    serve(0, $urandom, 1'b0);
    serve(0, $urandom, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      bit any;
      any = 1'b0;
      for (int r = 0; r < N; r++) begin
        if (!pv[r] && $urandom_range(0, 1) == 1) new_req(r);
        if (pv[r]) any = 1'b1;
      end
      if (!any) new_req($urandom_range(0, N - 1));
      rd = $urandom;
      serve($urandom_range(0, 4), rd, 1'b0);
    end
    while (model_pick() >= 0) serve(0, $urandom, 1'b0);

`ifdef APB_TIMEOUT_EN
    // Slave never answers: abort after exactly TO ACCESS cycles
    begin
      int g;
      new_req(0);
      g = model_pick();
      last = g;
      tick();
      chk("to_setup_ready", 64'(req_ready), 64'(1) << g);
      pv[g] = 1'b0;
      apb_bus.pready = 1'b0;
      for (int i = 0; i < TO; i++) begin
        tick();
        chk("to_access_penable", 64'(apb_bus.penable), 64'(1));
        chk("to_access_rsp_valid", 64'(rsp_valid), 64'(0));
      end
      tick();
      chk("to_rsp_valid", 64'(rsp_valid), 64'(1) << g);
      chk("to_rsp_err", 64'(rsp_err), 64'(1));
      chk("to_rsp_rdata", 64'(rsp_rdata), 64'(32'hDEAD_BEEF));
      chk("to_psel", 64'(apb_bus.psel), 64'(0));
      chk("to_busy", 64'(busy), 64'(0));
    end
    // pready arriving on the last allowed cycle completes normally
    new_req(1);
    serve(TO - 1, $urandom, 1'b0);
`else
    // Without the timeout a long wait still completes normally
    new_req(1);
    serve(TO + 4, $urandom, 1'b0);
`endif

    tick();
    chk("final_idle_busy", 64'(busy), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares one APB master port between NUM_REQ independent requesters, e.g. several ICB-side bridge channels or a debug/config port.
- Round-robin arbitration picks one request at a time. A three-state APB FSM (IDLE/SETUP/ACCESS) runs the transfer and routes the response back to the granted requester.
- Drives the master side of the existing APB bus interface.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, address width; must equal APB paddr width.
- DATA_W, 32, data width; must equal APB pwdata/prdata width.
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit (used only with APB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester transfer request; held until req_ready.
- req_ready  out  NUM_REQ  one-cycle acknowledge to the granted requester.
- req_write  in  NUM_REQ  per-requester 1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing as req_addr.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  DATA_W  shared read data; valid while any rsp_valid bit is 1.
- rsp_err  out  1  shared error flag; valid while any rsp_valid bit is 1.
- grant_id  out  3  index of the current or last granted requester.
- busy  out  1  1 while the FSM is in SETUP or ACCESS.
- psel, penable, pwrite  out  1  APB control.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.

Behaviour:
Reset:
- rst=1 asynchronously clears psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid, rsp_rdata, rsp_err, grant_id and busy to 0.
- State goes to IDLE; the round-robin pointer last_grant goes to NUM_REQ-1, so requester 0 wins first after reset.
- A transfer cut by reset produces no rsp_valid, and no state or pointer survives it.

FSM (registered outputs):
- IDLE: psel=0, penable=0.
  - If any req_valid is 1, grant g = first set index scanning from last_grant+1 modulo NUM_REQ.
  - On that edge: latch pwrite/paddr/pwdata from slice g, set grant_id=g, last_grant=g, and go to SETUP.
- SETUP (one cycle): psel=1, penable=0, req_ready[g]=1 for this cycle only; then go to ACCESS.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata stay stable.
  - While pready=0, stay in ACCESS.
  - On pready=1, go to IDLE. The next cycle drives rsp_valid[g]=1, rsp_err=0, and rsp_rdata = prdata (read) or 0 (write).
- Response: rsp_valid and rsp_rdata are registered and held for exactly one cycle, then return to 0.
- Arbitration happens only in IDLE. Requests arriving in SETUP/ACCESS wait, and a requester's request must not be re-arbitrated before it sees req_ready.
- Every transfer passes through one IDLE cycle, so there is no ACCESS→SETUP chaining.
- Latency with zero wait states: req_valid seen in IDLE at cycle 0 → SETUP at 1 → ACCESS at 2 (pready=1) → rsp_valid at 3. Each wait state adds one cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0…
- A single active requester is granted on every arbitration.
- req_valid bits for non-granted requesters are ignored; unused slices of the packed buses are don't-care.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined: an ACCESS-cycle counter starts at 0 on entry to ACCESS.
  - If pready is still 0 after TIMEOUT_CYCLES ACCESS cycles, the FSM drops psel/penable and goes to IDLE.
  - The next cycle pulses rsp_valid[g] with rsp_err=1 and rsp_rdata=32'hDEAD_BEEF.
  - A pready=1 seen in the same cycle the limit is reached completes normally (rsp_err=0).
- Not defined: ACCESS waits indefinitely for pready, no counter is built, and rsp_err is tied to 0.

Test Plan:
- Write, no wait states: req0 write addr 0x1000_0004 data 0xA5A5_0001, pready=1 → SETUP/ACCESS on cycles 1/2 with that paddr/pwdata, pwrite=1; req_ready[0] on cycle 1; rsp_valid[0] on cycle 3 with rsp_rdata=0.
- Read, 3 wait states: req1 read addr 0x20; pready low for 3 ACCESS cycles, then high with prdata=0x1234_5678 → penable high for 4 cycles; rsp_valid[1] with rsp_rdata=0x1234_5678; paddr stable throughout.
- Contention: req0 and req1 held valid for 4 transfers from reset → grant order 0,1,0,1; grant_id matches; never two bits of req_ready or rsp_valid set together.
- Reset mid-ACCESS: assert rst while penable=1, pready=0 → psel/penable drop to 0 in the same cycle without a clock edge; no rsp_valid; after release req1-only valid → req1 granted; req0+req1 valid → req0 granted first.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=16): pready held 0 → exactly 16 ACCESS cycles, then rsp_valid with rsp_err=1, rsp_rdata=0xDEAD_BEEF, FSM back in IDLE.
- Timeout boundary: pready=1 on the 16th ACCESS cycle → normal completion with rsp_err=0.
